mod_delay_line: RTL and testbench

Modulated fractional delay line for the chorus effect. It sits directly downstream of the LFO generator and consumes its signed wave and new-value flag. On each audio sample strobe it writes the incoming sample into a circular buffer, then reads back two adjacent taps at BASE_DELAY ± LFO offset. It linearly interpolates between the taps and outputs the dry/wet average with a one-cycle valid pulse.

---
 rtl/chorus_pkg.sv | 18 +
 rtl/delay_ram.sv | 25 ++
 rtl/mod_delay_line.sv | 181 ++++++++++++++++++
 tb/tb_mod_delay_line.sv | 229 ++++++++++++++++++++++
 4 files changed

// File: rtl/chorus_pkg.sv
// Shared types and widths for the chorus datapath blocks.
package chorus_pkg;

  localparam int FRAC_W  = 8;
  localparam int LFO_W   = 16;
  localparam int AUDIO_W = 16;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WRITE,
    ST_RD_A,
    ST_RD_B,
    ST_CAP_B,
    ST_INTERP,
    ST_OUT
  } lfo_delay_state_t;

endpackage

// File: rtl/delay_ram.sv
// Single-port synchronous RAM, one-cycle read latency, no reset so it maps to block RAM.
module delay_ram #(
  parameter int ADDR_W = 10,
  parameter int DATA_W = 16
) (
  input  logic              clk_i,
  input  logic              we_i,
  input  logic [ADDR_W-1:0] addr_i,
  input  logic [DATA_W-1:0] wdata_i,
  output logic [DATA_W-1:0] rdata_o
);

  logic [DATA_W-1:0] r_mem [2**ADDR_W];
  logic [DATA_W-1:0] r_rdata;

  always_ff @(posedge clk_i) begin
    if (we_i) begin
      r_mem[addr_i] <= wdata_i;
    end
    r_rdata <= r_mem[addr_i];
  end

  assign rdata_o = r_rdata;

endmodule

// File: rtl/mod_delay_line.sv
// Chorus modulated fractional delay: circular buffer, two-tap linear interpolation, dry/wet average.
module mod_delay_line
  import chorus_pkg::*;
#(
  parameter int ADDR_W     = 10,
  parameter int BASE_DELAY = 256
) (
  input  logic        clk_i,
  input  logic        reset_i,
  input  logic        sampleValid_i,
  input  logic [15:0] sample_i,
  input  logic [15:0] lfo_i,
  input  logic        lfoValid_i,
  output logic [15:0] sample_o,
  output logic        sampleValid_o,
  output logic        busy_o,
  output logic        overrun_o
);

  localparam int DLY_W  = ADDR_W + FRAC_W;
  localparam int PROD_W = AUDIO_W + 1 + FRAC_W + 1;
  localparam logic [DLY_W-1:0] BASE_FIX = DLY_W'(BASE_DELAY * (2**FRAC_W));
  localparam logic [ADDR_W:0]  FILL_MAX = (ADDR_W+1)'(BASE_DELAY + 130);

  if (BASE_DELAY < 129 || BASE_DELAY > (2**ADDR_W) - 130) begin : g_bad_base
    $error("mod_delay_line: BASE_DELAY outside [129, 2^ADDR_W-130]");
  end

  function automatic logic signed [AUDIO_W-1:0] f_interp(
    input logic signed [AUDIO_W-1:0] a,
    input logic signed [AUDIO_W-1:0] b,
    input logic        [FRAC_W-1:0]  frac
  );
    logic signed [AUDIO_W:0]   diff;
    logic signed [PROD_W-1:0]  prod;
    logic signed [PROD_W-1:0]  acc;
    diff = $signed({b[AUDIO_W-1], b}) - $signed({a[AUDIO_W-1], a});
    prod = $signed({{(PROD_W-AUDIO_W-1){diff[AUDIO_W]}}, diff})
         * $signed({{(PROD_W-FRAC_W){1'b0}}, frac});
    acc  = $signed({{(PROD_W-AUDIO_W){a[AUDIO_W-1]}}, a}) + (prod >>> FRAC_W);
    return acc[AUDIO_W-1:0];
  endfunction

  // Halving the 17-bit sum by dropping its LSB floors toward -inf.
  function automatic logic signed [AUDIO_W-1:0] f_mix(
    input logic signed [AUDIO_W-1:0] dry,
    input logic signed [AUDIO_W-1:0] wet
  );
    logic signed [AUDIO_W:0] sum;
    sum = $signed({dry[AUDIO_W-1], dry}) + $signed({wet[AUDIO_W-1], wet});
    return sum[AUDIO_W:1];
  endfunction

  lfo_delay_state_t r_state;
  lfo_delay_state_t w_next;

  logic signed [AUDIO_W-1:0] r_dry;
  logic signed [AUDIO_W-1:0] r_tapA;
  logic signed [AUDIO_W-1:0] r_tapB;
  logic signed [AUDIO_W-1:0] r_wet;
  logic signed [AUDIO_W-1:0] r_hold;
  logic        [LFO_W-1:0]   r_lfoReg;
  logic        [LFO_W-1:0]   r_lfoSnap;
  logic        [ADDR_W-1:0]  r_wrPtr;
  logic        [ADDR_W:0]    r_fillCnt;
  logic                      r_overrun;

  logic        [DLY_W-1:0]   w_delayFix;
  logic        [ADDR_W-1:0]  w_intD;
  logic        [FRAC_W-1:0]  w_frac;
  logic        [ADDR_W-1:0]  w_addrA;
  logic        [ADDR_W-1:0]  w_addrB;
  logic        [ADDR_W-1:0]  w_ramAddr;
  logic                      w_ramWe;
  logic        [AUDIO_W-1:0] w_ramRdata;
  logic                      w_accept;
  logic                      w_primed;
  logic signed [AUDIO_W-1:0] w_mix;

  assign w_accept   = (r_state == ST_IDLE) && sampleValid_i;
  assign w_primed   = (r_fillCnt == FILL_MAX);
  assign w_delayFix = BASE_FIX + {{(DLY_W-LFO_W){r_lfoSnap[LFO_W-1]}}, r_lfoSnap};
  assign w_intD     = w_delayFix[DLY_W-1:FRAC_W];
  assign w_frac     = w_delayFix[FRAC_W-1:0];
  assign w_addrA    = r_wrPtr - w_intD;
  assign w_addrB    = w_addrA - 1'b1;
  assign w_mix      = f_mix(r_dry, r_wet);

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next    = r_state;
    w_ramWe   = 1'b0;
    w_ramAddr = r_wrPtr;
    unique case (r_state)
      ST_IDLE:   if (sampleValid_i) w_next = ST_WRITE;
      ST_WRITE:  begin
        w_ramWe = 1'b1;
        w_next  = ST_RD_A;
      end
      ST_RD_A:   begin
        w_ramAddr = w_addrA;
        w_next    = ST_RD_B;
      end
      ST_RD_B:   begin
        w_ramAddr = w_addrB;
        w_next    = ST_CAP_B;
      end
      ST_CAP_B:  w_next = ST_INTERP;
      ST_INTERP: w_next = ST_OUT;
      ST_OUT:    w_next = ST_IDLE;
      default:   w_next = ST_IDLE;
    endcase
  end

  delay_ram #(
    .ADDR_W (ADDR_W),
    .DATA_W (AUDIO_W)
  ) u_ram (
    .clk_i   (clk_i),
    .we_i    (w_ramWe),
    .addr_i  (w_ramAddr),
    .wdata_i (r_dry),
    .rdata_o (w_ramRdata)
  );

  // Datapath stage registers: accept, tap capture, interpolation.
  always_ff @(posedge clk_i) begin
    if (w_accept) begin
      r_dry     <= sample_i;
      r_lfoSnap <= lfoValid_i ? lfo_i : r_lfoReg;
    end
    if (r_state == ST_RD_B) begin
      r_tapA <= w_ramRdata;
    end
    if (r_state == ST_CAP_B) begin
      r_tapB <= w_ramRdata;
    end
    if (r_state == ST_INTERP) begin
      r_wet <= w_primed ? f_interp(r_tapA, r_tapB, w_frac) : '0;
    end
  end

  // Control state: LFO hold, pointer, priming count, overrun flag, output hold.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      r_lfoReg  <= '0;
      r_wrPtr   <= '0;
      r_fillCnt <= '0;
      r_overrun <= 1'b0;
      r_hold    <= '0;
    end else begin
      if (lfoValid_i) begin
        r_lfoReg <= lfo_i;
      end
      if (sampleValid_i && (r_state != ST_IDLE)) begin
        r_overrun <= 1'b1;
      end
      if (r_state == ST_OUT) begin
        r_hold  <= w_mix;
        r_wrPtr <= r_wrPtr + 1'b1;
        if (!w_primed) begin
          r_fillCnt <= r_fillCnt + 1'b1;
        end
      end
    end
  end

  // The mix appears combinationally during OUT and is held afterwards.
  assign sample_o      = (r_state == ST_OUT) ? w_mix : r_hold;
  assign sampleValid_o = (r_state == ST_OUT);
  assign busy_o        = (r_state != ST_IDLE);
  assign overrun_o     = r_overrun;

endmodule

// File: tb/tb_mod_delay_line.sv
// Self-checking bench for mod_delay_line: directed tables, impulse echoes, corner sequences, random vs model.
module tb_mod_delay_line;

  localparam int ADDR_W = 10;
  localparam int BASE   = 256;
  localparam int PRIME  = BASE + 130;

  logic        clk = 1'b0;
  logic        reset_i = 1'b0;
  logic        sampleValid_i = 1'b0;
  logic [15:0] sample_i = '0;
  logic [15:0] lfo_i = '0;
  logic        lfoValid_i = 1'b0;
  logic [15:0] sample_o;
  logic        sampleValid_o;
  logic        busy_o;
  logic        overrun_o;

  int checks   = 0;
  int failures = 0;
  int hist[$];
  int lfo_cur  = 0;

  typedef struct {
    int s;
    int exp;
  } vec_t;

  mod_delay_line #(.ADDR_W(ADDR_W), .BASE_DELAY(BASE)) dut (
    .clk_i         (clk),
    .reset_i       (reset_i),
    .sampleValid_i (sampleValid_i),
    .sample_i      (sample_i),
    .lfo_i         (lfo_i),
    .lfoValid_i    (lfoValid_i),
    .sample_o      (sample_o),
    .sampleValid_o (sampleValid_o),
    .busy_o        (busy_o),
    .overrun_o     (overrun_o)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d", name, act, exp);
    end
  endtask

  // Reference: output from the sample history since reset and the spec's delay rules.
  function automatic int model_out(input int dry, input int lfo);
    int n, d, intD, frac, a, b, wet;
    n = hist.size();
    if (n < PRIME) return dry >>> 1;
    d    = BASE * 256 + lfo;
    intD = d / 256;
    frac = d % 256;
    a    = hist[n - intD];
    b    = hist[n - intD - 1];
    wet  = a + (((b - a) * frac) >>> 8);
    return (dry + wet) >>> 1;
  endfunction

  task automatic do_reset();
    @(negedge clk);
    reset_i = 1'b1;
    sampleValid_i = 1'b0;
    lfoValid_i = 1'b0;
    repeat (3) @(negedge clk);
    reset_i = 1'b0;
    hist.delete();
    lfo_cur = 0;
  endtask

  task automatic do_sample(input int s, input bit lfo_v, input int lfo_val,
                           input bit mid, input int mid_val, input int exp,
                           input string name);
    int c;
    bit seen, busy_ok;
    @(negedge clk);
    sample_i      = s[15:0];
    sampleValid_i = 1'b1;
    lfoValid_i    = lfo_v;
    if (lfo_v) lfo_i = lfo_val[15:0];
    @(negedge clk);
    sampleValid_i = 1'b0;
    lfoValid_i    = 1'b0;
    c = 1; seen = 0; busy_ok = 1;
    while (!seen && c <= 10) begin
      if (busy_o !== 1'b1) busy_ok = 0;
      if (sampleValid_o === 1'b1) seen = 1;
      else begin
        if (mid && c == 2) begin
          lfoValid_i = 1'b1;
          lfo_i = mid_val[15:0];
        end else begin
          lfoValid_i = 1'b0;
        end
        @(negedge clk);
        c++;
      end
    end
    lfoValid_i = 1'b0;
    check({name, " latency"}, seen ? c : -1, 6);
    check({name, " busy"}, int'(busy_ok), 1);
    check({name, " value"}, int'($signed(sample_o)), exp);
  endtask

  task automatic step(input int s, input bit lfo_v, input int lfo_val,
                      input bit mid, input int mid_val, input int exp, input string name);
    do_sample(s, lfo_v, lfo_val, mid, mid_val, exp, name);
    hist.push_back(s);
    if (lfo_v) lfo_cur = lfo_val;
    if (mid) lfo_cur = mid_val;
  endtask

  task automatic run_model(input int s, input bit lfo_v, input int lfo_val,
                           input bit mid, input int mid_val, input string name);
    int exp;
    exp = model_out(s, lfo_v ? lfo_val : lfo_cur);
    step(s, lfo_v, lfo_val, mid, mid_val, exp, name);
  endtask

  initial begin
    vec_t vecs[8];
    int nv, vcyc, s, lv, mv, exp;
    bit lb, mb;

    vecs[0] = '{0, 0};           vecs[1] = '{1, 0};
    vecs[2] = '{-1, -1};         vecs[3] = '{-3, -2};
    vecs[4] = '{32767, 16383};   vecs[5] = '{-32768, -16384};
    vecs[6] = '{16384, 8192};    vecs[7] = '{12345, 6172};

    // Reset values and unprimed dry-only outputs
    do_reset();
    check("reset sample_o", int'(sample_o), 0);
    check("reset sampleValid_o", int'(sampleValid_o), 0);
    check("reset busy_o", int'(busy_o), 0);
    check("reset overrun_o", int'(overrun_o), 0);
    for (int i = 0; i < 8; i++) begin
      step(vecs[i].s, 1'b0, 0, 1'b0, 0, vecs[i].exp, "unprimed");
    end
    @(negedge clk);
    check("hold sample_o", int'($signed(sample_o)), 6172);
    check("hold sampleValid_o", int'(sampleValid_o), 0);
    check("idle busy_o", int'(busy_o), 0);

    // Integer delay impulse
    do_reset();
    for (int i = 0; i < 700; i++) begin
      s   = (i == 400) ? 16384 : 0;
      exp = (i == 400 || i == 656) ? 8192 : 0;
      step(s, i == 0, 0, 1'b0, 0, exp, "int_delay");
    end

    // Fractional delay, half-sample offset
    do_reset();
    for (int i = 0; i < 700; i++) begin
      s   = (i == 400) ? 16384 : 0;
      exp = (i == 400) ? 8192 : ((i == 656 || i == 657) ? 4096 : 0);
      step(s, i == 0, 128, 1'b0, 0, exp, "frac_delay");
    end

    // Minimum delay with write pointer wrap
    do_reset();
    for (int i = 0; i < 1150; i++) begin
      s   = (i == 400 || i == 700 || i == 1000) ? 16384 : 0;
      exp = (s != 0 || i == 528 || i == 828 || i == 1128) ? 8192 : 0;
      step(s, i == 0, -32768, 1'b0, 0, exp, "min_delay_wrap");
    end

    // Overrun: second strobe two cycles after the first is dropped
    do_reset();
    nv = 0; vcyc = -1;
    for (int k = 0; k < 14; k++) begin
      @(negedge clk);
      if (sampleValid_o === 1'b1) begin nv++; vcyc = k; end
      sampleValid_i = (k == 0 || k == 2);
      sample_i = (k == 0) ? 16'd100 : 16'd300;
    end
    sampleValid_i = 1'b0;
    check("overrun valid count", nv, 1);
    check("overrun valid cycle", vcyc, 6);
    check("overrun sample_o", int'($signed(sample_o)), 50);
    check("overrun set", int'(overrun_o), 1);
    hist.push_back(100);
    step(10, 1'b0, 0, 1'b0, 0, 5, "after_overrun");
    check("overrun sticky", int'(overrun_o), 1);
    do_reset();
    check("overrun cleared", int'(overrun_o), 0);

    // Reset mid-operation after priming
    for (int i = 0; i < 400; i++) begin
      run_model(1000 + 37 * i, 1'b0, 0, 1'b0, 0, "prime");
    end
    nv = 0;
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      if (sampleValid_o === 1'b1) nv++;
      sampleValid_i = (k == 0);
      sample_i = 16'd5000;
      reset_i = (k == 3);
    end
    sampleValid_i = 1'b0;
    reset_i = 1'b0;
    hist.delete();
    lfo_cur = 0;
    check("midreset no valid", nv, 0);
    check("midreset busy_o", int'(busy_o), 0);
    step(-7, 1'b0, 0, 1'b0, 0, -4, "midreset dry_only");

    // Random samples and LFO changes, including updates while busy
    do_reset();
    for (int i = 0; i < 1000; i++) begin
      s  = int'($urandom_range(65535)) - 32768;
      lb = ($urandom_range(4) == 0);
      lv = int'($urandom_range(65535)) - 32768;
      mb = ($urandom_range(5) == 0);
      mv = int'($urandom_range(65535)) - 32768;
      run_model(s, lb, lv, mb, mv, "random");
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
